// File: rtl/polygon_area_acc_if.sv
// Vertex stream in, doubled polygon area out.
// Master drives vertices; slave returns area2/done.
interface polygon_area_acc_if;
  logic [2:0]  point_num;
  logic        valid;
  logic [9:0]  Xin;
  logic [9:0]  Yin;
  logic [23:0] area2;
  logic        done;

  modport master (
    output point_num, valid, Xin, Yin,
    input  area2, done
  );

  modport slave (
    input  point_num, valid, Xin, Yin,
    output area2, done
  );
endinterface

// File: rtl/polygon_area_acc.sv
// Shoelace accumulator over a sorted vertex stream.
// Define ABS_AREA_EN to report |2*area| instead of signed.
module polygon_area_acc (
  input  logic              clk,
  input  logic              reset,
  polygon_area_acc_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ACC,
    CLOSE,
    DONE
  } state_e;

  state_e      state_q;
  logic [9:0]  x0_q, y0_q;
  logic [9:0]  px_q, py_q;
  logic [2:0]  n_q, cnt_q;
  logic [23:0] acc_q;
  logic [23:0] area2_q;
  logic        done_q;

  logic [19:0] p_a, p_b, c_a, c_b;
  logic [23:0] term_acc, term_close;
  logic [23:0] acc_fin, res;
  logic [2:0]  n_first;

  assign p_a = {10'b0, px_q} * {10'b0, bus.Yin};
  assign p_b = {10'b0, bus.Xin} * {10'b0, py_q};
  assign c_a = {10'b0, px_q} * {10'b0, y0_q};
  assign c_b = {10'b0, x0_q} * {10'b0, py_q};

  assign term_acc   = {4'b0, p_a} - {4'b0, p_b};
  assign term_close = {4'b0, c_a} - {4'b0, c_b};
  assign acc_fin    = acc_q + term_close;

`ifdef ABS_AREA_EN
  assign res = acc_fin[23] ? (~acc_fin + 24'd1) : acc_fin;
`else
  assign res = acc_fin;
`endif

  // a zero vertex count is treated as a single point
  assign n_first = (bus.point_num == 3'd0) ? 3'd1 : bus.point_num;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      area2_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.valid) begin
            x0_q    <= bus.Xin;
            y0_q    <= bus.Yin;
            px_q    <= bus.Xin;
            py_q    <= bus.Yin;
            n_q     <= n_first;
            cnt_q   <= 3'd1;
            acc_q   <= '0;
            state_q <= (n_first == 3'd1) ? CLOSE : ACC;
          end else begin
            state_q <= IDLE;
          end
        end
        ACC: begin
          if (bus.valid) begin
            acc_q <= acc_q + term_acc;
            px_q  <= bus.Xin;
            py_q  <= bus.Yin;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q + 3'd1 == n_q) begin
              state_q <= CLOSE;
            end
          end
        end
        CLOSE: begin
          acc_q   <= acc_fin;
          area2_q <= res;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.area2 = area2_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_polygon_area_acc.sv
// Directed bench for polygon_area_acc.
// Shoelace model plus per-cycle done/area2 compare.
module tb_polygon_area_acc;
  logic clk = 1'b0;
  logic reset;

  polygon_area_acc_if bus ();

  polygon_area_acc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          c;
    logic [23:0] v;
  } exp_t;

  exp_t        q[$];
  logic [23:0] held = '0;
  logic        prev_done = 1'b0;
  int          errs = 0;
  int          checks = 0;
  int          sx[8];
  int          sy[8];

  task automatic chk(input string nm,
                     input logic [23:0] act,
                     input logic [23:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s t=%0t actual=%h required=%h",
               nm, $time, act, req);
    end
  endtask

  function automatic logic [23:0] shoelace(input int n);
    int s;
    int j;
    s = 0;
    for (int i = 0; i < n; i++) begin
      j = (i + 1) % n;
      s += sx[i] * sy[j] - sx[j] * sy[i];
    end
`ifdef ABS_AREA_EN
    if (s < 0) s = -s;
`endif
    return s[23:0];
  endfunction

  always @(negedge clk) begin
    logic exp_d;
    if (reset) begin
      q.delete();
      held = '0;
    end
    exp_d = 1'b0;
    if (q.size() > 0 && q[0].c == cyc) begin
      exp_d = 1'b1;
      held  = q[0].v;
      void'(q.pop_front());
    end
    chk("done", {23'b0, bus.done}, {23'b0, exp_d});
    chk("area2", bus.area2, held);
    chk("done_twice", {23'b0, bus.done & prev_done}, 24'd0);
    prev_done = bus.done;
  end

  task automatic beat(input int pn, input int x, input int y);
    bus.point_num = pn[2:0];
    bus.valid     = 1'b1;
    bus.Xin       = x[9:0];
    bus.Yin       = y[9:0];
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic poly(input int pn, input int gap);
    int   n;
    exp_t e;
    n = (pn == 0) ? 1 : pn;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        e.c = cyc + 2;
        e.v = shoelace(n);
        q.push_back(e);
      end
      beat(pn, sx[i], sy[i]);
      if (i < n - 1) idle(gap);
    end
  endtask

  task automatic set_sq_ccw();
    sx = '{0, 10, 10, 0, 0, 0, 0, 0};
    sy = '{0, 0, 10, 10, 0, 0, 0, 0};
  endtask

  initial begin
    reset         = 1'b1;
    bus.valid     = 1'b0;
    bus.point_num = '0;
    bus.Xin       = '0;
    bus.Yin       = '0;
    idle(3);
    reset = 1'b0;
    idle(2);

    set_sq_ccw();
    poly(4, 0);
    idle(3);
    chk("sq_ccw", bus.area2, 24'd200);

    sx = '{0, 0, 10, 10, 0, 0, 0, 0};
    sy = '{0, 10, 10, 0, 0, 0, 0, 0};
    poly(4, 0);
    idle(3);
`ifdef ABS_AREA_EN
    chk("sq_cw", bus.area2, 24'd200);
`else
    chk("sq_cw", bus.area2, 24'hFFFF38);
`endif

    sx = '{0, 1023, 0, 0, 0, 0, 0, 0};
    sy = '{0, 0, 1023, 0, 0, 0, 0, 0};
    poly(3, 2);
    idle(3);
    chk("tri_max", bus.area2, 24'd1046529);

    sx = '{4, 0, 0, 0, 0, 0, 0, 0};
    sy = '{4, 0, 0, 0, 0, 0, 0, 0};
    poly(0, 0);
    idle(3);
    chk("n0", bus.area2, 24'd0);

    set_sq_ccw();
    poly(4, 0);
    idle(3);
    chk("sq_again", bus.area2, 24'd200);

    sx = '{5, 900, 0, 0, 0, 0, 0, 0};
    sy = '{7, 3, 0, 0, 0, 0, 0, 0};
    poly(2, 1);
    idle(3);
    chk("n2", bus.area2, 24'd0);

    set_sq_ccw();
    poly(4, 0);
    idle(1);
    sx = '{2, 4, 6, 4, 2, 0, 0, 0};
    sy = '{0, 0, 2, 4, 4, 2, 0, 0};
    poly(6, 0);
    idle(3);
    chk("hex_b2b", bus.area2, 24'd32);

    // a beat offered during CLOSE must be ignored
    set_sq_ccw();
    poly(4, 0);
    beat(3, 700, 900);
    idle(4);
    chk("close_drop", bus.area2, 24'd200);

    beat(4, 0, 0);
    beat(4, 10, 0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("rst_area", bus.area2, 24'd0);
    idle(5);
    chk("rst_quiet", bus.area2, 24'd0);

    set_sq_ccw();
    poly(4, 0);
    idle(3);
    chk("sq_post_rst", bus.area2, 24'd200);

    idle(2);
    chk("pending", q.size(), 24'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
